// File: rtl/spi_stream_arbiter.sv
// Round-robin merge of CLIENTS byte streams onto one SPI transmit stream; grant is held per packet.
// Define ARB_FAST_REARB_EN to re-arbitrate on the last beat and remove the idle cycle between packets.
module spi_stream_arbiter #(
    parameter int WIDTH   = 8,
    parameter int CLIENTS = 2,
    parameter int ID_W    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CLIENTS-1:0]         req_valid,
    input  logic [WIDTH*CLIENTS-1:0]   req_data,
    input  logic [CLIENTS-1:0]         req_last,
    output logic [CLIENTS-1:0]         req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [CLIENTS-1:0]         grant,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    // Handshake: a beat moves when valid and ready are both high on a rising clk edge;
    // valid never waits on ready, and ready only reaches the current owner.

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [ID_W-1:0]   ptr_inc;
    logic [ID_W:0]     pick_idle;
    logic              last_xfer;
`ifdef ARB_FAST_REARB_EN
    logic [ID_W:0]     pick_fast;
`endif

    // Returns {found, index} of the first valid bit at or above start, wrapping at CLIENTS-1.
    function automatic logic [ID_W:0] pick(input logic [ID_W-1:0] start,
                                           input logic [CLIENTS-1:0] v);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            idx = int'(start) + i;
            if (idx >= CLIENTS) idx = idx - CLIENTS;
            if (v[idx]) r = {1'b1, idx[ID_W-1:0]};
        end
        return r;
    endfunction

    assign ptr_inc   = (owner == ID_W'(CLIENTS - 1)) ? '0 : owner + ID_W'(1);
    assign last_xfer = req_valid[owner] && out_ready && req_last[owner];
    assign pick_idle = pick(ptr, req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
`ifdef ARB_FAST_REARB_EN
        pick_fast = pick(ptr_inc, req_valid);
`endif
        case (state)
            IDLE: begin
                if (pick_idle[ID_W]) begin
                    state_nxt = LOCKED;
                    owner_nxt = pick_idle[ID_W-1:0];
                end
            end
            LOCKED: begin
                if (last_xfer) begin
                    ptr_nxt   = ptr_inc;
                    state_nxt = IDLE;
`ifdef ARB_FAST_REARB_EN
                    if (pick_fast[ID_W]) begin
                        state_nxt = LOCKED;
                        owner_nxt = pick_fast[ID_W-1:0];
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy mirrors the state register, so it doubles as the FSM observation point.
    always_comb begin
        req_ready = '0;
        grant     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        grant_id  = owner;
        if (state == LOCKED) begin
            busy             = 1'b1;
            grant[owner]     = 1'b1;
            out_valid        = req_valid[owner];
            out_data         = req_data[int'(owner)*WIDTH +: WIDTH];
            out_last         = req_last[owner];
            req_ready[owner] = out_ready;
        end
    end

endmodule
